btn_step_debouncer: RTL

//  Cleans a raw push-button input into a single-cycle step pulse and a debounced level.

---
 rtl/btn_pkg.sv | 12 +
 rtl/btn_sync.sv | 21 ++
 rtl/btn_step_debouncer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and sizing helper for the push-button step debouncer.
package btn_pkg;

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} btn_state_t;

  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Flop-chain synchroniser for an asynchronous input; resets to a chosen level.
module btn_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ff <= {STAGES{RESET_VAL}};
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/btn_step_debouncer.sv
// Push-button debouncer producing a one-cycle step pulse and a debounced level.
// Optional hold-to-repeat stepping is enabled by defining BTN_STEP_DEBOUNCER_AUTO_REPEAT_EN.
//
// state        | meaning
// IDLE         | released, stable
// PRESS_WAIT   | input went pressed, counting stable cycles
// PRESSED      | press accepted, btn_level high
// RELEASE_WAIT | input went released, counting stable cycles
module btn_step_debouncer
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int DEBOUNCE_CYCLES     = 500_000,
  parameter int BTN_ACTIVE_HIGH     = 1,
  parameter int REPEAT_DELAY_CYCLES = 25_000_000,
  parameter int REPEAT_RATE_CYCLES  = 5_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic step,
  output logic btn_level,
  output logic busy
);

  localparam int               CNT_W     = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY_CYCLES);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic             REL_LEVEL = (BTN_ACTIVE_HIGH != 0) ? 1'b0 : 1'b1;

  // A repeat rate of 1 would emit back-to-back steps.
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || REPEAT_RATE_CYCLES < 2) begin : g_param_check
    $error("btn_step_debouncer: SYNC_STAGES, DEBOUNCE_CYCLES and REPEAT_RATE_CYCLES must be >= 2");
  end

  logic       raw_sync;
  logic       p;
  btn_state_t state;
  logic [CNT_W-1:0] cnt;

  btn_sync #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (REL_LEVEL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_raw),
    .q     (raw_sync)
  );

  assign p = (BTN_ACTIVE_HIGH != 0) ? raw_sync : ~raw_sync;

`ifdef BTN_STEP_DEBOUNCER_AUTO_REPEAT_EN
  localparam int              HOLD_W    = cnt_width(REPEAT_DELAY_CYCLES, REPEAT_RATE_CYCLES);
  localparam logic [HOLD_W-1:0] RPT_DELAY = HOLD_W'(REPEAT_DELAY_CYCLES);
  localparam logic [HOLD_W-1:0] RPT_RATE  = HOLD_W'(REPEAT_RATE_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = '1;

  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_first;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      step      <= 1'b0;
      btn_level <= 1'b0;
      busy      <= 1'b0;
`ifdef BTN_STEP_DEBOUNCER_AUTO_REPEAT_EN
      hold_cnt   <= '0;
      hold_first <= 1'b0;
`endif
    end else begin
      step <= 1'b0;
`ifdef BTN_STEP_DEBOUNCER_AUTO_REPEAT_EN
      // Hold counter only survives a cycle spent in PRESSED; every exit clears it.
      hold_cnt   <= '0;
      hold_first <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (p) begin
            state <= PRESS_WAIT;
            cnt   <= CNT_W'(1);
            busy  <= 1'b1;
          end
        end
        PRESS_WAIT: begin
          if (!p) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else if (cnt == DEB_LAST) begin
            state     <= PRESSED;
            cnt       <= '0;
            step      <= 1'b1;
            btn_level <= 1'b1;
            busy      <= 1'b0;
`ifdef BTN_STEP_DEBOUNCER_AUTO_REPEAT_EN
            hold_cnt   <= HOLD_W'(1);
            hold_first <= 1'b1;
`endif
          end else begin
            cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!p) begin
            state <= RELEASE_WAIT;
            cnt   <= CNT_W'(1);
            busy  <= 1'b1;
          end
`ifdef BTN_STEP_DEBOUNCER_AUTO_REPEAT_EN
          else if (hold_cnt == (hold_first ? RPT_DELAY : RPT_RATE)) begin
            step       <= 1'b1;
            hold_cnt   <= HOLD_W'(1);
            hold_first <= 1'b0;
          end else begin
            hold_cnt   <= (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
            hold_first <= hold_first;
          end
`endif
        end
        RELEASE_WAIT: begin
          if (p) begin
            state <= PRESSED;
            cnt   <= '0;
            busy  <= 1'b0;
`ifdef BTN_STEP_DEBOUNCER_AUTO_REPEAT_EN
            hold_cnt   <= HOLD_W'(1);
            hold_first <= 1'b1;
`endif
          end else if (cnt == DEB_LAST) begin
            state     <= IDLE;
            cnt       <= '0;
            btn_level <= 1'b0;
            busy      <= 1'b0;
          end else begin
            cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
